// File: rtl/bs_rr_router_bcst.sv
// bs_rr_router_bcst: round-robin router from DRVRS source FIFOs to DRVRS sinks.
// Each packet takes one walk through IDLE -> POP -> DEC -> PUSH.
// The top ID_W bits of a packet select one sink or, when all ones, every sink
// except the sender. An undeliverable packet is dropped: either its destination
// is invalid, or its targets stay full for TIMEOUT cycles. Every drop is counted.
// All outputs are decoded from registered state, so there is no path from an
// input straight through to an output.
module bs_rr_router_bcst #(
    parameter int PCKG_SZ = 16,
    parameter int DRVRS   = 8,
    parameter int ID_W    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DRVRS-1:0]           pndng,
    input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
    input  logic [DRVRS-1:0]           full,
    output logic [DRVRS-1:0]           pop,
    output logic [DRVRS-1:0]           push,
    output logic [DRVRS*PCKG_SZ-1:0]   D_push,
    output logic [15:0]                drop_cnt,
    output logic                       busy
);

    localparam int GW = (DRVRS > 1) ? $clog2(DRVRS) : 1;
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, POP, DEC, PUSH} state_t;

    state_t             state, state_nxt;
    logic [GW-1:0]      gnt;         // driver being served
    logic [GW-1:0]      last_grant;  // round-robin pointer
    logic [GW-1:0]      arb_gnt;
    logic [PCKG_SZ-1:0] pkt;
    logic [SW-1:0]      stall_cnt;
    logic [ID_W-1:0]    dest;
    logic [DRVRS-1:0]   gnt_oh;
    logic [DRVRS-1:0]   mask;
    logic               dest_uni, dest_bcst, dest_bad;
    logic               blocked, stall_out, drop;

    assign dest = pkt[PCKG_SZ-1 -: ID_W];

    // Round-robin search: the first pending driver found upward from last_grant+1.
    // The search wraps. It runs from the far end back toward the pointer, so the
    // nearest pending driver is the one that remains.
    always_comb begin : arb
        int idx;
        arb_gnt = '0;
        idx     = 0;
        for (int off = DRVRS; off >= 1; off--) begin
            idx = int'(last_grant) + off;
            if (idx >= DRVRS) idx = idx - DRVRS;
            if (pndng[idx]) arb_gnt = GW'(idx);
        end
    end

    // Target decode from the captured packet. The broadcast mask excludes the sender.
    always_comb begin
        gnt_oh    = '0;
        mask      = '0;
        dest_uni  = (32'(dest) < 32'(DRVRS));
        dest_bcst = !dest_uni && (dest == {ID_W{1'b1}});
        dest_bad  = !dest_uni && !dest_bcst;
        for (int i = 0; i < DRVRS; i++) begin
            gnt_oh[i] = (gnt == GW'(i));
            if (dest_uni) mask[i] = (32'(dest) == 32'(i));
        end
        if (dest_bcst) mask = ~gnt_oh;
    end

    // Any full target holds the whole packet, so a broadcast is never partial.
    assign blocked   = |(mask & full);
    assign stall_out = (stall_cnt == STALL_MAX);
    assign drop      = (state == DEC) && (dest_bad || (blocked && stall_out));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (|pndng) state_nxt = POP;
            POP:  state_nxt = DEC;
            DEC: begin
                if (dest_bad)      state_nxt = IDLE;
                else if (!blocked) state_nxt = PUSH;
                else if (stall_out) state_nxt = IDLE;
            end
            PUSH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: grant capture, packet capture, stall timer, drop counter and
    // pointer update. A reset while a packet is in flight discards the packet
    // without counting it as a drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt        <= '0;
            last_grant <= GW'(DRVRS - 1);
            pkt        <= '0;
            stall_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (|pndng) gnt <= arb_gnt;
                POP: begin
                    pkt       <= D_pop[int'(gnt)*PCKG_SZ +: PCKG_SZ];
                    stall_cnt <= '0;
                end
                DEC: begin
                    if (drop) begin
                        last_grant <= gnt;
                        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                    end else if (blocked) begin
                        stall_cnt <= stall_cnt + SW'(1);
                    end
                end
                PUSH: last_grant <= gnt;
                default: ;
            endcase
        end
    end

    // Output decode from registered state.
    always_comb begin
        pop    = (state == POP)  ? gnt_oh : '0;
        push   = (state == PUSH) ? mask   : '0;
        D_push = (state == PUSH) ? {DRVRS{pkt}} : '0;
        busy   = (state != IDLE);
    end

endmodule
